// File: rtl/axil_mem_responder_if.sv
// AXI4-Lite subordinate bus bundle for axil_mem_responder.
// Signal names keep the responder's i_/o_ view; the master modport mirrors directions.
interface axil_mem_responder_if #(
  parameter int AW = 12
);
  logic [AW-1:0] i_awaddr;
  logic          i_awvalid;
  logic          o_awready;
  logic [31:0]   i_wdata;
  logic [3:0]    i_wstrb;
  logic          i_wvalid;
  logic          o_wready;
  logic [1:0]    o_bresp;
  logic          o_bvalid;
  logic          i_bready;
  logic [AW-1:0] i_araddr;
  logic          i_arvalid;
  logic          o_arready;
  logic [31:0]   o_rdata;
  logic [1:0]    o_rresp;
  logic          o_rlast;
  logic          o_rvalid;
  logic          i_rready;

  modport slave (
    input  i_awaddr, i_awvalid, i_wdata, i_wstrb, i_wvalid, i_bready,
           i_araddr, i_arvalid, i_rready,
    output o_awready, o_wready, o_bresp, o_bvalid,
           o_arready, o_rdata, o_rresp, o_rlast, o_rvalid
  );

  modport master (
    output i_awaddr, i_awvalid, i_wdata, i_wstrb, i_wvalid, i_bready,
           i_araddr, i_arvalid, i_rready,
    input  o_awready, o_wready, o_bresp, o_bvalid,
           o_arready, o_rdata, o_rresp, o_rlast, o_rvalid
  );
endinterface

// File: rtl/axil_mem_responder.sv
// AXI4-Lite subordinate backed by a word-wide memory; one transaction in flight,
// read/write alternation when both requests contend.
module axil_mem_responder #(
  parameter int AW      = 12,
  parameter int MEMSIZE = 4096,
  parameter     MEMFILE = ""
) (
  input logic                 clk,
  input logic                 rst,
  axil_mem_responder_if.slave bus
);
  localparam int          DEPTH = MEMSIZE / 4;
  localparam int          IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] LIMIT = MEMSIZE[AW:0];

  typedef enum logic [1:0] {IDLE, WR_WAIT_W, WR_RESP, RD_RESP} state_t;

  state_t        r_state, w_next;
  logic          r_prio;  // 0: write wins a tie, 1: read wins
  logic [AW-1:0] r_awaddr;
  logic [1:0]    r_bresp, r_rresp;
  logic [31:0]   r_rdata;
  logic [31:0]   r_mem [DEPTH];

  logic          w_awready, w_wready, w_arready;
  logic          w_we, w_aw_latch, w_ar_hs, w_b_done, w_r_done;
  logic [AW-1:0] w_waddr;
  logic          w_wr_oob, w_rd_oob;
  logic [IW-1:0] w_widx, w_ridx;

  assign w_waddr  = (r_state == IDLE) ? bus.i_awaddr : r_awaddr;
  assign w_wr_oob = {1'b0, w_waddr} >= LIMIT;
  assign w_rd_oob = {1'b0, bus.i_araddr} >= LIMIT;
  assign w_widx   = w_waddr[IW+1:2];
  assign w_ridx   = bus.i_araddr[IW+1:2];

  always_comb begin
    w_next     = r_state;
    w_awready  = 1'b0;
    w_wready   = 1'b0;
    w_arready  = 1'b0;
    w_we       = 1'b0;
    w_aw_latch = 1'b0;
    w_ar_hs    = 1'b0;
    w_b_done   = 1'b0;
    w_r_done   = 1'b0;
    if (rst) begin
      case (r_state)
        IDLE: begin
          if (bus.i_awvalid && (!bus.i_arvalid || !r_prio)) begin
            w_awready = 1'b1;
            w_wready  = 1'b1;
            if (bus.i_wvalid) begin
              w_we   = 1'b1;
              w_next = WR_RESP;
            end else begin
              w_aw_latch = 1'b1;
              w_next     = WR_WAIT_W;
            end
          end else if (bus.i_arvalid) begin
            w_arready = 1'b1;
            w_ar_hs   = 1'b1;
            w_next    = RD_RESP;
          end
        end
        WR_WAIT_W: begin
          w_wready = 1'b1;
          if (bus.i_wvalid) begin
            w_we   = 1'b1;
            w_next = WR_RESP;
          end
        end
        WR_RESP: begin
          if (bus.i_bready) begin
            w_b_done = 1'b1;
            w_next   = IDLE;
          end
        end
        RD_RESP: begin
          if (bus.i_rready) begin
            w_r_done = 1'b1;
            w_next   = IDLE;
          end
        end
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_prio  <= 1'b0;
      r_bresp <= 2'b00;
      r_rresp <= 2'b00;
      r_rdata <= 32'h0;
    end else begin
      r_state <= w_next;
      if (w_aw_latch) r_awaddr <= bus.i_awaddr;
      if (w_we)       r_bresp  <= w_wr_oob ? 2'b10 : 2'b00;
      if (w_ar_hs) begin
        r_rresp <= w_rd_oob ? 2'b10 : 2'b00;
        r_rdata <= w_rd_oob ? 32'h0 : r_mem[w_ridx];
      end
      // Priority goes to the type not served last.
      if (w_b_done) r_prio <= 1'b1;
      if (w_r_done) r_prio <= 1'b0;
    end
  end

  // Storage is never reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (w_we && !w_wr_oob) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.i_wstrb[b]) r_mem[w_widx][8*b +: 8] <= bus.i_wdata[8*b +: 8];
      end
    end
  end

  assign bus.o_awready = w_awready;
  assign bus.o_wready  = w_wready;
  assign bus.o_arready = w_arready;
  assign bus.o_bvalid  = (r_state == WR_RESP);
  assign bus.o_bresp   = r_bresp;
  assign bus.o_rvalid  = (r_state == RD_RESP);
  assign bus.o_rlast   = (r_state == RD_RESP);
  assign bus.o_rresp   = r_rresp;
  assign bus.o_rdata   = r_rdata;
endmodule

// File: tb/tb_axil_mem_responder.sv
// Directed bench for axil_mem_responder: scoreboard queues of expected B/R
// responses filled at stimulus time, drained when the responder answers.
module tb_axil_mem_responder;
  localparam int AW = 13;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axil_mem_responder_if #(.AW(AW)) bus ();
  axil_mem_responder #(.AW(AW), .MEMSIZE(4096), .MEMFILE("")) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct packed { logic [1:0] resp; logic [31:0] data; } exp_t;
  exp_t        bq[$];
  exp_t        rq[$];
  logic [31:0] mdl [1024];
  int          vecs = 0;
  int          miss = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic get_b(input int hold, input bit poke);
    exp_t e;
    int   n = 0;
    e = '0;
    @(negedge clk); #1;
    while (bus.o_bvalid !== 1'b1 && n < 16) begin @(negedge clk); #1; n++; end
    chk("b_latency", 64'(n), 64'd0);
    if (bq.size() == 0) begin
      vecs++; miss++;
      $error("FAIL b_scoreboard: got empty queue want one entry");
    end else e = bq.pop_front();
    if (poke) begin bus.i_awvalid = 1'b1; bus.i_arvalid = 1'b1; end
    for (int i = 0; i <= hold; i++) begin
      chk("b_hold", 64'({bus.o_bvalid, bus.o_bresp, bus.o_awready, bus.o_wready, bus.o_arready}),
          64'({1'b1, e.resp, 3'b000}));
      if (i == hold) bus.i_bready = 1'b1;
      @(negedge clk); #1;
    end
    bus.i_bready = 1'b0;
    if (poke) begin bus.i_awvalid = 1'b0; bus.i_arvalid = 1'b0; end
    chk("b_clear", 64'(bus.o_bvalid), 64'd0);
  endtask

  task automatic get_r(input int hold, input bit poke);
    exp_t e;
    int   n = 0;
    e = '0;
    @(negedge clk); #1;
    while (bus.o_rvalid !== 1'b1 && n < 16) begin @(negedge clk); #1; n++; end
    chk("r_latency", 64'(n), 64'd0);
    if (rq.size() == 0) begin
      vecs++; miss++;
      $error("FAIL r_scoreboard: got empty queue want one entry");
    end else e = rq.pop_front();
    if (poke) begin bus.i_awvalid = 1'b1; bus.i_arvalid = 1'b1; end
    for (int i = 0; i <= hold; i++) begin
      chk("r_hold", 64'({bus.o_rvalid, bus.o_rlast, bus.o_rresp, bus.o_rdata, bus.o_arready, bus.o_awready}),
          64'({1'b1, 1'b1, e.resp, e.data, 2'b00}));
      if (i == hold) bus.i_rready = 1'b1;
      @(negedge clk); #1;
    end
    bus.i_rready = 1'b0;
    if (poke) begin bus.i_awvalid = 1'b0; bus.i_arvalid = 1'b0; end
    chk("r_clear", 64'({bus.o_rvalid, bus.o_rlast}), 64'd0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                    input int gap, input int hold, input bit poke);
    exp_t e;
    e.data = 32'h0;
    e.resp = a[12] ? 2'b10 : 2'b00;
    if (!a[12])
      for (int b = 0; b < 4; b++) if (s[b]) mdl[a[11:2]][8*b +: 8] = d[8*b +: 8];
    bq.push_back(e);
    bus.i_awaddr  = a;
    bus.i_awvalid = 1'b1;
    bus.i_wdata   = d;
    bus.i_wstrb   = s;
    bus.i_wvalid  = (gap == 0);
    #1 chk("aw_grant", 64'({bus.o_awready, bus.o_wready, bus.o_arready}), 64'(3'b110));
    @(posedge clk); #1;
    bus.i_awvalid = 1'b0;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk); #1;
      chk("w_wait", 64'({bus.o_awready, bus.o_wready, bus.o_bvalid}), 64'(3'b010));
    end
    if (gap > 0) begin bus.i_wvalid = 1'b1; @(posedge clk); #1; end
    bus.i_wvalid = 1'b0;
    get_b(hold, poke);
  endtask

  task automatic rd(input logic [AW-1:0] a, input int hold, input bit poke);
    exp_t e;
    e.resp = a[12] ? 2'b10 : 2'b00;
    e.data = a[12] ? 32'h0 : mdl[a[11:2]];
    rq.push_back(e);
    bus.i_araddr  = a;
    bus.i_arvalid = 1'b1;
    #1 chk("ar_grant", 64'({bus.o_arready, bus.o_awready}), 64'(2'b10));
    @(posedge clk); #1;
    bus.i_arvalid = 1'b0;
    get_r(hold, poke);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    bus.i_awaddr = '0; bus.i_araddr = '0; bus.i_wdata = '0; bus.i_wstrb = '0;
    bus.i_awvalid = 1'b1; bus.i_wvalid = 1'b1; bus.i_arvalid = 1'b1;
    bus.i_bready = 1'b0; bus.i_rready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_out", 64'({bus.o_bvalid, bus.o_rvalid, bus.o_rlast, bus.o_bresp, bus.o_rresp, bus.o_rdata}), 64'd0);
    chk("reset_rdy", 64'({bus.o_awready, bus.o_wready, bus.o_arready}), 64'd0);
    bus.i_awvalid = 1'b0; bus.i_wvalid = 1'b0; bus.i_arvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk); #1;

    // Contention from reset: write first, then read, then write again.
    bus.i_arvalid = 1'b1;
    wr(13'h010, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    rd(13'h010, 0, 0);
    bus.i_arvalid = 1'b1;
    wr(13'h020, 32'hAAAAAAAA, 4'hF, 0, 0, 0);
    rd(13'h020, 0, 0);

    // W without AW is not accepted.
    bus.i_wvalid = 1'b1;
    bus.i_wdata  = 32'h01234567;
    #1 chk("w_alone", 64'({bus.o_awready, bus.o_wready, bus.o_bvalid}), 64'd0);
    @(negedge clk); #1;
    chk("w_alone_hold", 64'({bus.o_awready, bus.o_wready, bus.o_bvalid}), 64'd0);
    bus.i_wvalid = 1'b0;

    // Split AW/W with partial strobes, then a no-op strobe.
    wr(13'h020, 32'h11223344, 4'b0101, 3, 0, 0);
    rd(13'h020, 0, 0);
    wr(13'h020, 32'hFFFFFFFF, 4'b0000, 0, 0, 0);
    rd(13'h020, 0, 0);

    // Out-of-range accesses and ignored low address bits.
    wr(13'h000, 32'h12345678, 4'hF, 0, 0, 0);
    wr(13'h1000, 32'h55555555, 4'hF, 0, 0, 0);
    rd(13'h000, 0, 0);
    rd(13'h1000, 0, 0);
    rd(13'h013, 0, 0);

    // Backpressure with competing requests offered.
    wr(13'h040, 32'hCAFEF00D, 4'hF, 0, 5, 1);
    rd(13'h040, 5, 1);

    // Reset while a read response is pending.
    bus.i_araddr  = 13'h010;
    bus.i_arvalid = 1'b1;
    @(posedge clk); #1;
    bus.i_arvalid = 1'b0;
    @(negedge clk); #1;
    chk("rd_pre_rst", 64'({bus.o_rvalid, bus.o_rdata}), 64'({1'b1, mdl[4]}));
    rst = 1'b0;
    bus.i_awvalid = 1'b1; bus.i_arvalid = 1'b1;
    @(negedge clk); #1;
    chk("rst_mid", 64'({bus.o_rvalid, bus.o_rlast, bus.o_rresp, bus.o_rdata, bus.o_awready, bus.o_arready}), 64'd0);
    bus.i_awvalid = 1'b0; bus.i_arvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk); #1;
    chk("post_rst", 64'({bus.o_rvalid, bus.o_bvalid}), 64'd0);
    rd(13'h010, 0, 0);
    bus.i_arvalid = 1'b1;
    wr(13'h044, 32'h0BADCAFE, 4'hF, 0, 0, 0);
    rd(13'h044, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
